// File: rtl/rr_resource_arbiter_if.sv
// Request/grant bundle between the requesters and the shared-resource arbiter.
// The arbiter uses the slave side; requester logic and the bench use master.
interface rr_resource_arbiter_if #(
   parameter int N   = 4,
   parameter int IDW = 2
);
   logic [N-1:0]   REQ;
   logic [N-1:0]   DONE;
   logic [N-1:0]   GNT;
   logic [IDW-1:0] GNT_ID;
   logic           BUSY;
   logic           TIMEOUT;

   modport master (output REQ, DONE, input GNT, GNT_ID, BUSY, TIMEOUT);
   modport slave  (input REQ, DONE, output GNT, GNT_ID, BUSY, TIMEOUT);
endinterface

// File: rtl/rr_resource_arbiter.sv
// Round-robin owner selection for one shared resource: registered one-hot grant,
// release handshake, one dead cycle between owners and a hold-time watchdog.
module rr_resource_arbiter #(
   parameter int N        = 4,
   parameter int IDW      = 2,
   parameter int MAX_HOLD = 15
) (
   input logic                  CK,
   input logic                  RN,
   rr_resource_arbiter_if.slave bus
);
   localparam int CW = $clog2(MAX_HOLD + 1);

   typedef enum logic [1:0] {IDLE, OWN, GAP} state_t;

   state_t         state;
   logic [N-1:0]   gnt;
   logic [IDW-1:0] gnt_id;
   logic           busy;
   logic           timeout;
   logic [CW-1:0]  cnt;
   logic [IDW-1:0] ptr;

   logic           win_found;
   logic [IDW-1:0] win_idx;
   logic [IDW-1:0] cand;
   logic [IDW-1:0] next_ptr;
   logic           owner_release;
   logic           hold_expired;

   // Search upward from the pointer, wrapping N-1 -> 0; first set REQ wins.
   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int i = 0; i < N; i++) begin
         cand = IDW'((int'(ptr) + i) % N);
         if (!win_found && bus.REQ[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   assign next_ptr      = IDW'((int'(gnt_id) + 1) % N);
   assign owner_release = bus.DONE[gnt_id] || !bus.REQ[gnt_id];
   assign hold_expired  = (cnt == CW'(MAX_HOLD));

   // NOTE: asynchronous reset so the grant drops the moment RN falls, not at the next edge.
   always_ff @(posedge CK or negedge RN) begin
      if (!RN) begin
         state   <= IDLE;
         gnt     <= '0;
         gnt_id  <= '0;
         busy    <= 1'b0;
         timeout <= 1'b0;
         cnt     <= '0;
         ptr     <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         timeout <= 1'b0;
         case (state)
            IDLE, GAP: begin
               if (win_found) begin
                  state  <= OWN;
                  gnt    <= N'(1) << win_idx;
                  gnt_id <= win_idx;
                  busy   <= 1'b1;
                  cnt    <= CW'(1);
               end else begin
                  state <= IDLE;
               end
            end
            OWN: begin
               if (owner_release || hold_expired) begin
                  // DONE/withdrawal outrank the watchdog, so TIMEOUT only on a pure expiry.
                  timeout <= !owner_release;
                  state   <= GAP;
                  gnt     <= '0;
                  busy    <= 1'b0;
                  cnt     <= '0;
                  ptr     <= next_ptr;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.GNT     = gnt;
   assign bus.GNT_ID  = gnt_id;
   assign bus.BUSY    = busy;
   assign bus.TIMEOUT = timeout;
endmodule

// File: doc/rr_resource_arbiter.md
Name: rr_resource_arbiter

Overview:
- Round-robin arbiter sharing one physical resource (buffer/clock-buffer chain, single flop bank) among N requesters.
- Registered one-hot grant with release handshake; hold-time watchdog forces release from stuck owners.
- Sits between requester logic and the shared cell group; the only block that drives the resource select.

Parameters:
- N, 4, number of requesters (2..8).
- IDW, 2, width of GNT_ID; must equal ceil(log2(N)).
- MAX_HOLD, 15, maximum grant cycles before forced release (1..255).

Ports:
- CK  input  1  clock; all state on rising edge.
- RN  input  1  asynchronous active-low reset.
- REQ  input  N  per-requester request; level, held until granted and finished.
- DONE  input  N  per-requester release strobe; only the bit of the current owner is honoured.
- GNT  output  N  one-hot grant, registered; all-zero when no owner.
- GNT_ID  output  IDW  binary index of current or last owner.
- BUSY  output  1  high while any GNT bit is set.
- TIMEOUT  output  1  one-cycle pulse when the watchdog forces a release.

Behaviour:
- Reset (RN low, asynchronous): GNT=0, GNT_ID=0, BUSY=0, TIMEOUT=0, hold counter=0, priority pointer=0, FSM=IDLE. Outputs fall immediately on RN falling, not at the next edge.
- FSM states: IDLE, OWN, GAP.
- IDLE: if REQ!=0 at an edge, choose the winner and enter OWN. GNT, GNT_ID and BUSY are valid from that edge (1-cycle latency from REQ to GNT). Hold counter loads 1.
- Winner selection: the first set REQ bit searching upward from the pointer, wrapping N-1 -> 0. Pointer reset value is 0, so requester 0 has priority first.
- OWN: the counter increments each cycle while saturating at MAX_HOLD. Owner is index k. Release conditions are evaluated at each edge, highest priority first:
  - DONE[k]=1: normal release.
  - REQ[k]=0: owner withdrew; normal release with no TIMEOUT.
  - Counter == MAX_HOLD with neither of the above: forced release; TIMEOUT=1 for exactly the following cycle.
- On any release: GNT=0, BUSY=0, pointer=(k+1) mod N, enter GAP. GNT_ID holds k.
- GAP: exactly one cycle with no grant, giving a guaranteed dead cycle between owners. Then go to IDLE, or go directly to OWN if REQ!=0, using the updated pointer.
- Back-to-back: minimum grant spacing is owner release edge + 1 gap cycle + new grant edge. No two GNT bits are ever high together, and GNT never changes from one owner to another without an intervening all-zero cycle.
- DONE bits of non-owners are ignored in every state. DONE in IDLE or GAP is ignored.
- DONE[k] and the counter reaching MAX_HOLD on the same edge: DONE wins, TIMEOUT stays 0.
- Requests arriving during OWN or GAP wait; they are not lost because REQ is level-sensitive.
- A requester that drops REQ before being granted is simply skipped.
- Counter width is ceil(log2(MAX_HOLD+1)); no overflow because of saturation.
- MAX_HOLD=1: owner gets exactly one cycle unless it releases on that edge.

Test Plan:
- Reset: assert RN low mid-grant (GNT=0100) -> GNT=0000, BUSY=0, TIMEOUT=0 combinationally. After RN high with REQ=1111, the first grant is GNT=0001, GNT_ID=0.
- Round-robin fairness: REQ=1111 held, each owner pulses DONE 2 cycles after its grant -> grant order 0,1,2,3,0 with one all-zero GAP cycle between each.
- Watchdog: REQ=0010 held, DONE=0, MAX_HOLD=15 -> GNT=0010 for 15 cycles, then GNT=0000 and TIMEOUT=1 for one cycle. The next grant goes back to 1 after GAP, since it is the sole requester.
- Simultaneous: DONE[k] asserted on the same edge the counter hits MAX_HOLD -> release with TIMEOUT=0.
- Spurious release: owner 2, DONE=0001 pulsed -> no change, GNT stays 0100. REQ[2] dropped -> release, TIMEOUT=0, pointer=3.
- Wrap and skip: pointer=3, REQ=0101 -> GNT=0001 (wraps past 3). Next grant is index 2.
